// File: rtl/rbi_ring_inject_arb_pkg.sv
// Shared ring definitions for the ring-bus inject arbiter.
// Contents: slot field widths, OPM class codes, seq field positions,
// default ring slot struct and small OPM/seq decode helpers.
package rbi_ring_inject_arb_pkg;

   localparam int unsigned RBI_ADDR_W = 48;
   localparam int unsigned RBI_DATA_W = 128;
   localparam int unsigned RBI_SEQ_W  = 16;
   localparam int unsigned RBI_OPM_W  = 16;
   localparam int unsigned RBI_NODE_W = 8;
   localparam int unsigned RBI_TAG_W  = 8;
   localparam int unsigned RBI_STAT_W = 32;

   // seq[15:8] carries the node ID, seq[7:0] the requester tag
   localparam int unsigned SEQ_NODE_LSB = 8;
   localparam int unsigned SEQ_TAG_LSB  = 0;

   // OPM low byte codes; opm[7:6] is the class field
   localparam logic [7:0] OPM_EMPTY     = 8'h00;
   localparam logic [1:0] OPM_CLASS_RSP = 2'b01;
   localparam logic [7:0] OPM_LDX       = 8'h81;
   localparam logic [7:0] OPM_STX       = 8'h82;
   localparam logic [7:0] OPM_PFX       = 8'h83;
   localparam logic [7:0] OPM_SPX       = 8'h84;

   // Default-width ring slot payload
   typedef struct packed {
      logic [RBI_SEQ_W-1:0]  seq;
      logic [RBI_OPM_W-1:0]  opm;
      logic [RBI_ADDR_W-1:0] addr;
      logic [RBI_DATA_W-1:0] data;
   } ring_slot_t;

   function automatic logic opm_is_empty(input logic [RBI_OPM_W-1:0] opm);
      return opm[7:0] == OPM_EMPTY;
   endfunction

   function automatic logic opm_is_rsp(input logic [RBI_OPM_W-1:0] opm);
      return opm[7:6] == OPM_CLASS_RSP;
   endfunction

   function automatic logic [RBI_NODE_W-1:0] seq_node(input logic [RBI_SEQ_W-1:0] seq);
      return seq[SEQ_NODE_LSB +: RBI_NODE_W];
   endfunction

endpackage

// File: rtl/rbi_inject_rr.sv
// Two-way round-robin picker for ring injection with starvation override.
// Ports:
//   clock, reset           clock, async active-low reset
//   i_req_a_valid/b_valid  requester pending flags
//   i_slot_free            current slot can take an injection
//   o_grant_a_c/b_c        combinational grant for this cycle
// A requester whose wait counter reached WAIT_MAX beats the pointer; if both
// are saturated A wins. The pointer moves to the loser after every grant.
module rbi_inject_rr
   import rbi_ring_inject_arb_pkg::*;
#(
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic clock,
   input  logic reset,
   input  logic i_req_a_valid,
   input  logic i_req_b_valid,
   input  logic i_slot_free,
   output logic o_grant_a_c,
   output logic o_grant_b_c
);

   localparam int unsigned WAIT_W = $clog2(WAIT_MAX + 1);

   logic [WAIT_W-1:0] r_wait_a;
   logic [WAIT_W-1:0] r_wait_b;
   logic              r_ptr_b;   // 1: B has round-robin priority
   logic              w_sat_a;
   logic              w_sat_b;
   logic              w_pick_a;

   // Winner selection, qualified by slot availability
   always_comb begin
      w_sat_a  = (r_wait_a == WAIT_W'(WAIT_MAX));
      w_sat_b  = (r_wait_b == WAIT_W'(WAIT_MAX));
      w_pick_a = 1'b0;
      if (i_req_a_valid && i_req_b_valid) begin
         if (w_sat_a)      w_pick_a = 1'b1;
         else if (w_sat_b) w_pick_a = 1'b0;
         else              w_pick_a = !r_ptr_b;
      end else begin
         w_pick_a = i_req_a_valid;
      end
      o_grant_a_c = i_slot_free && i_req_a_valid && w_pick_a;
      o_grant_b_c = i_slot_free && i_req_b_valid && !w_pick_a;
   end

   // Pointer and saturating wait counters
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_ptr_b  <= 1'b0;
         r_wait_a <= '0;
         r_wait_b <= '0;
      end else begin
         if (o_grant_a_c)      r_ptr_b <= 1'b1;
         else if (o_grant_b_c) r_ptr_b <= 1'b0;

         if (o_grant_a_c || !i_req_a_valid) r_wait_a <= '0;
         else if (!w_sat_a)                 r_wait_a <= r_wait_a + WAIT_W'(1);

         if (o_grant_b_c || !i_req_b_valid) r_wait_b <= '0;
         else if (!w_sat_b)                 r_wait_b <= r_wait_b + WAIT_W'(1);
      end
   end

endmodule

// File: rtl/rbi_ring_inject_arb.sv
// Ring-bus node controller: one-cycle slot stage that removes responses
// addressed to this node into a held response register and injects local
// requests A/B into empty (or just-emptied) slots.
// Ports:
//   clock, reset                    clock, async active-low reset
//   unitNodeId                      this node's ID
//   ringSeqIn/OpmIn/AddrIn/DataIn   upstream slot
//   ringSeqOut/OpmOut/AddrOut/DataOut  downstream slot (registered)
//   reqA*/reqB*                     local requesters; reqXReady is combinational
//   rspValid/rspReady, rsp*         held response handshake and fields
// Optional feature macro RBI_INJARB_STATS_EN adds statInject/statStall counters.
module rbi_ring_inject_arb
   import rbi_ring_inject_arb_pkg::*;
#(
   parameter int unsigned ADDR_W   = RBI_ADDR_W,
   parameter int unsigned DATA_W   = RBI_DATA_W,
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [RBI_NODE_W-1:0] unitNodeId,
   input  logic [RBI_SEQ_W-1:0]  ringSeqIn,
   input  logic [RBI_OPM_W-1:0]  ringOpmIn,
   input  logic [ADDR_W-1:0]     ringAddrIn,
   input  logic [DATA_W-1:0]     ringDataIn,
   output logic [RBI_SEQ_W-1:0]  ringSeqOut,
   output logic [RBI_OPM_W-1:0]  ringOpmOut,
   output logic [ADDR_W-1:0]     ringAddrOut,
   output logic [DATA_W-1:0]     ringDataOut,
   input  logic                  reqAValid,
   output logic                  reqAReady,
   input  logic [RBI_TAG_W-1:0]  reqASeq,
   input  logic [RBI_OPM_W-1:0]  reqAOpm,
   input  logic [ADDR_W-1:0]     reqAAddr,
   input  logic [DATA_W-1:0]     reqAData,
   input  logic                  reqBValid,
   output logic                  reqBReady,
   input  logic [RBI_TAG_W-1:0]  reqBSeq,
   input  logic [RBI_OPM_W-1:0]  reqBOpm,
   input  logic [ADDR_W-1:0]     reqBAddr,
   input  logic [DATA_W-1:0]     reqBData,
   output logic                  rspValid,
   input  logic                  rspReady,
   output logic [RBI_SEQ_W-1:0]  rspSeq,
   output logic [RBI_OPM_W-1:0]  rspOpm,
   output logic [ADDR_W-1:0]     rspAddr,
   output logic [DATA_W-1:0]     rspData
`ifdef RBI_INJARB_STATS_EN
   ,
   output logic [RBI_STAT_W-1:0] statInject,
   output logic [RBI_STAT_W-1:0] statStall
`endif
);

   typedef struct packed {
      logic [RBI_SEQ_W-1:0] seq;
      logic [RBI_OPM_W-1:0] opm;
      logic [ADDR_W-1:0]    addr;
      logic [DATA_W-1:0]    data;
   } slot_t;

   slot_t r_slot;
   slot_t r_rsp;
   logic  r_rsp_valid;

   slot_t w_slot_in;
   slot_t w_slot_nxt;
   logic  w_empty_in;
   logic  w_our_rsp;
   logic  w_capture;
   logic  w_slot_free;
   logic  w_grant_a;
   logic  w_grant_b;

   // Slot classification; a captured response frees its slot this cycle
   always_comb begin
      w_slot_in.seq  = ringSeqIn;
      w_slot_in.opm  = ringOpmIn;
      w_slot_in.addr = ringAddrIn;
      w_slot_in.data = ringDataIn;
      w_empty_in  = opm_is_empty(ringOpmIn);
      w_our_rsp   = opm_is_rsp(ringOpmIn) && (seq_node(ringSeqIn) == unitNodeId);
      w_capture   = w_our_rsp && (!r_rsp_valid || rspReady);
      w_slot_free = w_empty_in || w_capture;
   end

   rbi_inject_rr #(
      .WAIT_MAX (WAIT_MAX)
   ) u_rr (
      .clock         (clock),
      .reset         (reset),
      .i_req_a_valid (reqAValid),
      .i_req_b_valid (reqBValid),
      .i_slot_free   (w_slot_free),
      .o_grant_a_c   (w_grant_a),
      .o_grant_b_c   (w_grant_b)
   );

   assign reqAReady = w_grant_a;
   assign reqBReady = w_grant_b;

   // Next downstream slot: injection, emptied slot, or bit-exact pass-through
   always_comb begin
      w_slot_nxt = w_slot_in;
      if (w_grant_a) begin
         w_slot_nxt.seq  = {unitNodeId, reqASeq};
         w_slot_nxt.opm  = reqAOpm;
         w_slot_nxt.addr = reqAAddr;
         w_slot_nxt.data = reqAData;
      end else if (w_grant_b) begin
         w_slot_nxt.seq  = {unitNodeId, reqBSeq};
         w_slot_nxt.opm  = reqBOpm;
         w_slot_nxt.addr = reqBAddr;
         w_slot_nxt.data = reqBData;
      end else if (w_capture) begin
         w_slot_nxt = '0;
      end
   end

   // Slot stage register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_slot <= '0;
      else        r_slot <= w_slot_nxt;
   end

   // Held response register; accept and capture in one cycle keeps valid high
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_rsp       <= '0;
         r_rsp_valid <= 1'b0;
      end else if (w_capture) begin
         r_rsp       <= w_slot_in;
         r_rsp_valid <= 1'b1;
      end else if (rspReady) begin
         r_rsp_valid <= 1'b0;
      end
   end

   assign ringSeqOut  = r_slot.seq;
   assign ringOpmOut  = r_slot.opm;
   assign ringAddrOut = r_slot.addr;
   assign ringDataOut = r_slot.data;
   assign rspValid    = r_rsp_valid;
   assign rspSeq      = r_rsp.seq;
   assign rspOpm      = r_rsp.opm;
   assign rspAddr     = r_rsp.addr;
   assign rspData     = r_rsp.data;

`ifdef RBI_INJARB_STATS_EN
   logic [RBI_STAT_W-1:0] r_stat_inject;
   logic [RBI_STAT_W-1:0] r_stat_stall;

   // Injection and stall counters, wrapping modulo 2^32
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_stat_inject <= '0;
         r_stat_stall  <= '0;
      end else begin
         if (w_grant_a || w_grant_b)
            r_stat_inject <= r_stat_inject + RBI_STAT_W'(1);
         if ((reqAValid || reqBValid) && !(w_grant_a || w_grant_b))
            r_stat_stall <= r_stat_stall + RBI_STAT_W'(1);
      end
   end

   assign statInject = r_stat_inject;
   assign statStall  = r_stat_stall;
`endif

endmodule

// File: tb/tb_rbi_ring_inject_arb.sv
// Self-checking bench for rbi_ring_inject_arb: directed vector table,
// hand-written multi-cycle sequences and a randomized run against a
// rule-level reference model.
module tb_rbi_ring_inject_arb;

   localparam int unsigned AW = 48;
   localparam int unsigned DW = 128;
   localparam logic [7:0]  NID = 8'h5A;
   localparam logic [15:0] LDX = 16'h0081;
   localparam logic [15:0] STX = 16'h0082;
   localparam logic [15:0] PFX = 16'h0083;

   logic          clock;
   logic          reset;
   logic [7:0]    unitNodeId;
   logic [15:0]   ringSeqIn, ringOpmIn, ringSeqOut, ringOpmOut;
   logic [AW-1:0] ringAddrIn, ringAddrOut;
   logic [DW-1:0] ringDataIn, ringDataOut;
   logic          reqAValid, reqAReady, reqBValid, reqBReady;
   logic [7:0]    reqASeq, reqBSeq;
   logic [15:0]   reqAOpm, reqBOpm;
   logic [AW-1:0] reqAAddr, reqBAddr;
   logic [DW-1:0] reqAData, reqBData;
   logic          rspValid, rspReady;
   logic [15:0]   rspSeq, rspOpm;
   logic [AW-1:0] rspAddr;
   logic [DW-1:0] rspData;
`ifdef RBI_INJARB_STATS_EN
   logic [31:0]   statInject, statStall;
`endif

   int n_vec  = 0;
   int n_miss = 0;

   rbi_ring_inject_arb dut (
      .clock       (clock),
      .reset       (reset),
      .unitNodeId  (unitNodeId),
      .ringSeqIn   (ringSeqIn),
      .ringOpmIn   (ringOpmIn),
      .ringAddrIn  (ringAddrIn),
      .ringDataIn  (ringDataIn),
      .ringSeqOut  (ringSeqOut),
      .ringOpmOut  (ringOpmOut),
      .ringAddrOut (ringAddrOut),
      .ringDataOut (ringDataOut),
      .reqAValid   (reqAValid),
      .reqAReady   (reqAReady),
      .reqASeq     (reqASeq),
      .reqAOpm     (reqAOpm),
      .reqAAddr    (reqAAddr),
      .reqAData    (reqAData),
      .reqBValid   (reqBValid),
      .reqBReady   (reqBReady),
      .reqBSeq     (reqBSeq),
      .reqBOpm     (reqBOpm),
      .reqBAddr    (reqBAddr),
      .reqBData    (reqBData),
      .rspValid    (rspValid),
      .rspReady    (rspReady),
      .rspSeq      (rspSeq),
      .rspOpm      (rspOpm),
      .rspAddr     (rspAddr),
      .rspData     (rspData)
`ifdef RBI_INJARB_STATS_EN
      ,
      .statInject  (statInject),
      .statStall   (statStall)
`endif
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic edge_sample();
      @(posedge clock);
      #1;
   endtask

   typedef struct {
      logic [15:0]   opm_in;
      logic [15:0]   seq_in;
      logic          a_v;
      logic          b_v;
      logic          rsp_rdy;
      logic          exp_a;
      logic          exp_b;
      logic [15:0]   exp_opm;
      logic [15:0]   exp_seq;
      logic [AW-1:0] exp_addr;
      logic          exp_rv;
      logic [15:0]   exp_rseq;
   } vec_t;

   vec_t tbl[12];

   // Reference model state (rule level)
   int            m_turn;      // 0: A next in round robin, 1: B next
   int            m_wa, m_wb;
   logic          m_rv;
   logic [15:0]   m_rseq, m_ropm;
   logic [AW-1:0] m_raddr;
   logic [DW-1:0] m_rdata;
   int unsigned   m_inj, m_stall;

   initial begin
      logic          ea, eb, empty, ours, cap, free, win_a, win_b;
      logic [15:0]   e_seq, e_opm;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_data;
      int            kind;

      reset = 1'b0;
      unitNodeId = NID;
      ringSeqIn = '0; ringOpmIn = '0;
      ringAddrIn = 48'hABC; ringDataIn = 128'hDEAD;
      reqAValid = 0; reqASeq = 8'h11; reqAOpm = LDX; reqAAddr = 48'h1000; reqAData = 128'hA5A5;
      reqBValid = 0; reqBSeq = 8'h22; reqBOpm = STX; reqBAddr = 48'h2000; reqBData = 128'h5A5A;
      rspReady = 0;

      //              opm    seq   a  b  r  eA eB eOpm  eSeq   eAddr    rv rseq
      tbl[0]  = '{16'h0000,16'h0000,0,0,0, 0,0,16'h0000,16'h0000,48'hABC, 0,16'h0};
      tbl[1]  = '{16'h0000,16'h0000,1,1,0, 1,0,LDX,     16'h5A11,48'h1000,0,16'h0};
      tbl[2]  = '{16'h0000,16'h0000,1,1,0, 0,1,STX,     16'h5A22,48'h2000,0,16'h0};
      tbl[3]  = '{16'h0000,16'h0000,1,1,0, 1,0,LDX,     16'h5A11,48'h1000,0,16'h0};
      tbl[4]  = '{16'h0000,16'h0000,1,1,0, 0,1,STX,     16'h5A22,48'h2000,0,16'h0};
      tbl[5]  = '{PFX,     16'h1234,1,1,0, 0,0,PFX,     16'h1234,48'hABC, 0,16'h0};
      tbl[6]  = '{16'h0041,16'h3307,0,0,0, 0,0,16'h0041,16'h3307,48'hABC, 0,16'h0};
      tbl[7]  = '{16'h0041,16'h5A77,0,1,0, 0,1,STX,     16'h5A22,48'h2000,1,16'h5A77};
      tbl[8]  = '{16'h0045,16'h5A78,0,0,0, 0,0,16'h0045,16'h5A78,48'hABC, 1,16'h5A77};
      tbl[9]  = '{16'h0000,16'h0000,0,0,1, 0,0,16'h0000,16'h0000,48'hABC, 0,16'h0};
      tbl[10] = '{16'h0042,16'h5A79,0,0,0, 0,0,16'h0000,16'h0000,48'h0,   1,16'h5A79};
      tbl[11] = '{16'h0000,16'h0000,1,0,1, 1,0,LDX,     16'h5A11,48'h1000,0,16'h0};

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      check("rst_opm", ringOpmOut, 16'h0);
      check("rst_seq", ringSeqOut, 16'h0);
      check("rst_rv", rspValid, 1'b0);
      check("rst_rseq", rspSeq, 16'h0);
      reset = 1'b1;

      // Directed vector table
      for (int i = 0; i < 12; i++) begin
         ringOpmIn = tbl[i].opm_in; ringSeqIn = tbl[i].seq_in;
         reqAValid = tbl[i].a_v; reqBValid = tbl[i].b_v; rspReady = tbl[i].rsp_rdy;
         #1;
         check($sformatf("v%0d_a_rdy", i), reqAReady, tbl[i].exp_a);
         check($sformatf("v%0d_b_rdy", i), reqBReady, tbl[i].exp_b);
         edge_sample();
         check($sformatf("v%0d_opm", i), ringOpmOut, tbl[i].exp_opm);
         check($sformatf("v%0d_seq", i), ringSeqOut, tbl[i].exp_seq);
         check($sformatf("v%0d_addr", i), ringAddrOut, tbl[i].exp_addr);
         check($sformatf("v%0d_rv", i), rspValid, tbl[i].exp_rv);
         if (tbl[i].exp_rv) check($sformatf("v%0d_rseq", i), rspSeq, tbl[i].exp_rseq);
      end

      // Full ring for 20 cycles: no grants, pass-through; then A wins by saturation
      rspReady = 0;
      reqAValid = 1; reqBValid = 1;
      for (int i = 0; i < 20; i++) begin
         ringOpmIn = PFX; ringSeqIn = 16'h4400 + 16'(i);
         #1;
         check("full_no_grant", {reqAReady, reqBReady}, 2'b00);
         edge_sample();
         check("full_pass", {ringOpmOut, ringSeqOut}, {PFX, 16'h4400 + 16'(i)});
      end
      ringOpmIn = 16'h0000; ringSeqIn = 16'h0000;
      #1;
      check("starve_grant", {reqAReady, reqBReady}, 2'b10);
      edge_sample();
      check("starve_seq", ringSeqOut, 16'h5A11);
      reqAValid = 0; reqBValid = 0;

      // Held response blocks capture; the response recirculates, then is captured
      ringOpmIn = 16'h0043; ringSeqIn = 16'h5A31; ringDataIn = 128'h1111;
      edge_sample();
      check("hold_cap_rv", rspValid, 1'b1);
      ringOpmIn = 16'h0044; ringSeqIn = 16'h5A32; ringDataIn = 128'h2222;
      edge_sample();
      check("hold_pass", {ringOpmOut, ringSeqOut}, {16'h0044, 16'h5A32});
      check("hold_pass_data", ringDataOut, 128'h2222);
      check("hold_keep", rspSeq, 16'h5A31);
      rspReady = 1;
      edge_sample();
      check("hold_recap_opm", ringOpmOut, 16'h0);
      check("hold_recap", {rspValid, rspSeq}, {1'b1, 16'h5A32});
      check("hold_recap_data", rspData, 128'h2222);
      rspReady = 0;
      ringDataIn = 128'hDEAD;

      // Asynchronous reset in the middle of an injection, with a response held
      ringOpmIn = 16'h0000; ringSeqIn = 16'h0000; reqAValid = 1;
      edge_sample();
      check("pre_rst_opm", ringOpmOut, LDX);
      reqAValid = 0;
      #2;
      reset = 1'b0;
      #1;
      check("async_rst_opm", ringOpmOut, 16'h0);
      check("async_rst_rv", rspValid, 1'b0);
`ifdef RBI_INJARB_STATS_EN
      check("async_rst_stat", {statInject, statStall}, 64'h0);
`endif
      edge_sample();
      reset = 1'b1;

      // Randomized run against the rule-level model
      m_turn = 0; m_wa = 0; m_wb = 0; m_rv = 0;
      m_rseq = '0; m_ropm = '0; m_raddr = '0; m_rdata = '0;
      m_inj = 0; m_stall = 0;
      for (int c = 0; c < 400; c++) begin
         kind = int'($urandom_range(0, 9));
         if (kind < 4) begin
            ringOpmIn = {8'($urandom), 8'h00};
            ringSeqIn = 16'($urandom);
         end else if (kind < 6) begin
            ringOpmIn = {8'($urandom), 2'b01, 6'($urandom)};
            ringSeqIn = {NID, 8'($urandom)};
         end else if (kind < 7) begin
            ringOpmIn = {8'($urandom), 2'b01, 6'($urandom)};
            ringSeqIn = {NID ^ 8'(($urandom_range(1, 255))), 8'($urandom)};
         end else begin
            ringOpmIn = {8'($urandom), 1'b1, 7'($urandom)};
            ringSeqIn = 16'($urandom);
         end
         ringAddrIn = {16'($urandom), 32'($urandom)};
         ringDataIn = {$urandom, $urandom, $urandom, $urandom};
         rspReady = 1'($urandom);
         if (!reqAValid) begin
            reqAValid = ($urandom_range(0, 2) != 0);
            reqASeq = 8'($urandom); reqAOpm = {8'($urandom), 1'b1, 7'($urandom)};
            reqAAddr = {16'($urandom), 32'($urandom)};
            reqAData = {$urandom, $urandom, $urandom, $urandom};
         end
         if (!reqBValid) begin
            reqBValid = ($urandom_range(0, 2) != 0);
            reqBSeq = 8'($urandom); reqBOpm = {8'($urandom), 1'b1, 7'($urandom)};
            reqBAddr = {16'($urandom), 32'($urandom)};
            reqBData = {$urandom, $urandom, $urandom, $urandom};
         end

         empty = (ringOpmIn[7:0] == 8'h00);
         ours  = (ringOpmIn[7:6] == 2'b01) && (ringSeqIn[15:8] == NID);
         cap   = ours && (!m_rv || rspReady);
         free  = empty || cap;
         win_a = 0; win_b = 0;
         if (free) begin
            if (reqAValid && reqBValid) begin
               if (m_wa == 15)      win_a = 1;
               else if (m_wb == 15) win_b = 1;
               else if (m_turn == 0) win_a = 1;
               else                 win_b = 1;
            end else begin
               win_a = reqAValid;
               win_b = reqBValid;
            end
         end
         if (win_a) begin
            e_seq = {NID, reqASeq}; e_opm = reqAOpm; e_addr = reqAAddr; e_data = reqAData;
         end else if (win_b) begin
            e_seq = {NID, reqBSeq}; e_opm = reqBOpm; e_addr = reqBAddr; e_data = reqBData;
         end else if (cap) begin
            e_seq = '0; e_opm = '0; e_addr = '0; e_data = '0;
         end else begin
            e_seq = ringSeqIn; e_opm = ringOpmIn; e_addr = ringAddrIn; e_data = ringDataIn;
         end

         #1;
         check($sformatf("rnd%0d_ready", c), {reqAReady, reqBReady}, {win_a, win_b});
         ea = reqAValid; eb = reqBValid;

         if (cap) begin
            m_rv = 1; m_rseq = ringSeqIn; m_ropm = ringOpmIn; m_raddr = ringAddrIn; m_rdata = ringDataIn;
         end else if (rspReady) begin
            m_rv = 0;
         end
         if (win_a) m_turn = 1;
         if (win_b) m_turn = 0;
         m_wa = (win_a || !ea) ? 0 : ((m_wa < 15) ? m_wa + 1 : 15);
         m_wb = (win_b || !eb) ? 0 : ((m_wb < 15) ? m_wb + 1 : 15);
         if (win_a || win_b) m_inj++;
         else if (ea || eb) m_stall++;

         edge_sample();
         if (win_a) reqAValid = 0;
         if (win_b) reqBValid = 0;
         check($sformatf("rnd%0d_slot", c), {ringSeqOut, ringOpmOut, ringAddrOut, ringDataOut},
               {e_seq, e_opm, e_addr, e_data});
         check($sformatf("rnd%0d_rv", c), rspValid, m_rv);
         if (m_rv)
            check($sformatf("rnd%0d_rsp", c), {rspSeq, rspOpm, rspAddr, rspData},
                  {m_rseq, m_ropm, m_raddr, m_rdata});
      end
`ifdef RBI_INJARB_STATS_EN
      check("stat_inject", statInject, 32'(m_inj));
      check("stat_stall", statStall, 32'(m_stall));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
